// File: rtl/datapath_sequencer.sv
// Multi-cycle MIPS control sequencer: fetches instructions over a req/valid handshake,
// decodes them and steps the datapath through its phases while tracking pc and instret.
module datapath_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        alu_zero,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        MemRead,
    output logic [2:0]  ALUControl,
    output logic [25:0] Inst,
    output logic [31:0] pc,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_R    = 3'd0,
        K_LW   = 3'd1,
        K_SW   = 3'd2,
        K_ADDI = 3'd3,
        K_BEQ  = 3'd4,
        K_ILL  = 3'd5
    } kind_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic [2:0] alu_ctl;
    } ctl_t;

    function automatic kind_t decode_kind(input logic [5:0] op, input logic [5:0] funct);
        kind_t k;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: k = K_R;
                    default: k = K_ILL;
                endcase
            end
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b001000: k = K_ADDI;
            6'b000100: k = K_BEQ;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic ctl_t decode_ctl(input kind_t k, input logic [5:0] funct);
        ctl_t c;
        c = ctl_t'(7'd0);
        case (k)
            K_R: begin
                c.reg_dst    = 1'b1;
                c.mem_to_reg = 1'b1;
                case (funct)
                    6'b100000: c.alu_ctl = 3'b101;
                    6'b100010: c.alu_ctl = 3'b110;
                    6'b100100: c.alu_ctl = 3'b000;
                    6'b100101: c.alu_ctl = 3'b001;
                    6'b101010: c.alu_ctl = 3'b111;
                    default:   c.alu_ctl = 3'b000;
                endcase
            end
            K_LW: begin
                c.alu_src  = 1'b1;
                c.mem_read = 1'b1;
                c.alu_ctl  = 3'b101;
            end
            K_SW: begin
                c.alu_src = 1'b1;
                c.alu_ctl = 3'b101;
            end
            K_ADDI: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_ctl    = 3'b101;
            end
            K_BEQ:   c.alu_ctl = 3'b110;
            default: c = ctl_t'(7'd0);
        endcase
        return c;
    endfunction

    state_t      r_state, w_state_nxt;
    kind_t       r_kind, w_kind_nxt, w_fetch_kind;
    ctl_t        r_ctl, w_ctl_nxt;
    logic [25:0] r_inst, w_inst_nxt;
    logic [31:0] r_pc, w_pc_nxt, r_instret, w_instret_nxt;
    logic [31:0] w_pc_seq, w_pc_branch;
    logic        r_req, w_req_nxt;
    logic        r_reg_write, w_reg_write_nxt;
    logic        r_mem_write, w_mem_write_nxt;
    logic        r_illegal, w_illegal_nxt;
    logic        w_end, w_count, w_take;

    assign w_fetch_kind = decode_kind(imem_rdata[31:26], imem_rdata[5:0]);
    assign w_pc_seq     = r_pc + PC_STEP;
    assign w_pc_branch  = r_pc + 32'd4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

    // Next-state and next-output logic; outputs are registered so they track the state they belong to.
    always_comb begin
        w_state_nxt     = r_state;
        w_kind_nxt      = r_kind;
        w_ctl_nxt       = r_ctl;
        w_inst_nxt      = r_inst;
        w_pc_nxt        = r_pc;
        w_instret_nxt   = r_instret;
        w_req_nxt       = 1'b0;
        w_reg_write_nxt = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_illegal_nxt   = 1'b0;
        w_end           = 1'b0;
        w_count         = 1'b0;
        w_take          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_FETCH;
                    w_req_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    w_state_nxt   = S_DECODE;
                    w_kind_nxt    = w_fetch_kind;
                    w_ctl_nxt     = decode_ctl(w_fetch_kind, imem_rdata[5:0]);
                    w_inst_nxt    = imem_rdata[25:0];
                    w_illegal_nxt = (w_fetch_kind == K_ILL);
                end else if (run) begin
                    w_req_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DECODE: begin
                if (r_kind == K_ILL) begin
                    w_end = 1'b1;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_kind)
                    K_BEQ: begin
                        w_end   = 1'b1;
                        w_count = 1'b1;
                        w_take  = alu_zero;
                    end
                    K_LW, K_SW: begin
                        w_state_nxt     = S_MEM;
                        w_mem_write_nxt = (r_kind == K_SW);
                    end
                    default: begin
                        w_state_nxt     = S_WB;
                        w_reg_write_nxt = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (r_kind == K_LW) begin
                    w_state_nxt     = S_WB;
                    w_reg_write_nxt = 1'b1;
                end else begin
                    w_end   = 1'b1;
                    w_count = 1'b1;
                end
            end
            S_WB: begin
                w_end   = 1'b1;
                w_count = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Retire (or skip of an illegal word): advance pc, release controls, pick next fetch.
        if (w_end) begin
            w_state_nxt   = run ? S_FETCH : S_IDLE;
            w_req_nxt     = run;
            w_ctl_nxt     = ctl_t'(7'd0);
            w_inst_nxt    = 26'd0;
            w_pc_nxt      = w_take ? w_pc_branch : w_pc_seq;
            w_instret_nxt = w_count ? (r_instret + 32'd1) : r_instret;
        end else begin
            w_pc_nxt      = r_pc;
            w_instret_nxt = r_instret;
        end
    end

    // State, architectural counters and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_kind      <= K_ILL;
            r_ctl       <= ctl_t'(7'd0);
            r_inst      <= 26'd0;
            r_pc        <= PC_RESET;
            r_instret   <= 32'd0;
            r_req       <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_kind      <= w_kind_nxt;
            r_ctl       <= w_ctl_nxt;
            r_inst      <= w_inst_nxt;
            r_pc        <= w_pc_nxt;
            r_instret   <= w_instret_nxt;
            r_req       <= w_req_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_illegal   <= w_illegal_nxt;
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign instret    = r_instret;
    assign Inst       = r_inst;
    assign RegDst     = r_ctl.reg_dst;
    assign ALUSrc     = r_ctl.alu_src;
    assign MemToReg   = r_ctl.mem_to_reg;
    assign MemRead    = r_ctl.mem_read;
    assign ALUControl = r_ctl.alu_ctl;
    assign RegWrite   = r_reg_write;
    assign MemWrite   = r_mem_write;
    assign illegal    = r_illegal;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control sequencer that acts as the initiator for the `datapath` block.
- Fetches 32-bit MIPS instructions from instruction memory over a req/valid handshake.
- Decodes each instruction and drives the datapath's control strobes and 26-bit `Inst` field phase by phase.
- Tracks PC and a retired-instruction count.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential instruction.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
run  input  1  level; 1 = fetch and execute instructions, 0 = halt at next fetch boundary.
imem_req  output  1  fetch request, held until accepted.
imem_addr  output  32  fetch address (= pc).
imem_valid  input  1  fetch data valid; completes the handshake when imem_req=1.
imem_rdata  input  32  fetched instruction.
alu_zero  input  1  datapath ALU zero flag, sampled in EXEC of beq.
RegDst  output  1  1 = write-back register is rd [15:11]; 0 = rt [20:16].
RegWrite  output  1  register-file write strobe.
ALUSrc  output  1  1 = ALU operand B is sign-extended immediate.
MemWrite  output  1  data-memory write strobe.
MemToReg  output  1  1 = write back ALU result; 0 = write back memory data.
MemRead  output  1  data-memory read enable.
ALUControl  output  3  ALU operation select.
Inst  output  26  instruction bits [25:0] presented to the datapath.
pc  output  32  current PC.
illegal  output  1  one-cycle pulse on an unsupported opcode/funct.
instret  output  32  count of retired instructions, wraps modulo 2^32.

Behaviour:
- **Reset (async, rst_n=0):** state=IDLE, pc=PC_RESET, instret=0, Inst=0, and every control output, imem_req and illegal go to 0 immediately. Reset taken mid-instruction abandons it with no strobes issued.
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB.
- **IDLE:** go to FETCH when run=1.
- **FETCH:** imem_req=1 and imem_addr=pc. On the first cycle with imem_valid=1:
  - latch imem_rdata into the instruction register;
  - deassert imem_req the following cycle;
  - go to DECODE.
  - imem_valid while in any state other than FETCH is ignored.
- **DECODE (1 cycle):** drive Inst = IR[25:0] and the level controls, held stable until the instruction retires. Decode table by opcode IR[31:26] (controls listed are 1; all others 0):
  - 000000 R-type: RegDst, MemToReg. ALUControl from funct IR[5:0]: 100000 add=101, 100010 sub=110, 100100 and=000, 100101 or=001, 101010 slt=111.
  - 100011 lw: ALUSrc, MemRead; MemToReg=0; ALUControl=101.
  - 101011 sw: ALUSrc; ALUControl=101.
  - 001000 addi: ALUSrc, MemToReg; ALUControl=101.
  - 000100 beq: ALUControl=110; ALUSrc=0.
  - Any other opcode, or an R-type funct not in the table: pulse illegal for 1 cycle, instret not incremented, pc += PC_STEP, go to FETCH (or IDLE if run=0).
- **Phase sequences:**
  - R-type and addi: DECODE, EXEC, WB.
  - lw: DECODE, EXEC, MEM, WB.
  - sw: DECODE, EXEC, MEM.
  - beq: DECODE, EXEC.
- **Write strobes:**
  - RegWrite=1 only during the single WB cycle.
  - MemWrite=1 only during the single MEM cycle of sw.
  - MemRead stays high from DECODE through WB for lw.
- **Retire:** occurs on the last phase of each instruction.
  - instret += 1.
  - pc += PC_STEP, except taken beq: in EXEC, if alu_zero=1 then pc = pc + 4 + (signext(IR[15:0]) << 2), 32-bit wraparound.
  - The cycle after retire, all control outputs return to 0 and state goes to FETCH if run=1, otherwise IDLE.
- **run:** run=0 mid-instruction completes the current instruction. run=0 during FETCH before imem_valid drops imem_req and returns to IDLE.
- **Timing:** minimum instruction latency is 4 cycles (R-type with zero-wait fetch). Fetch wait states add one cycle each.

Test Plan:
1. add $1,$2,$3: imem_rdata=32'h00430820, imem_valid on first req cycle.
   - Inst=26'h0430820; RegDst=1, MemToReg=1, ALUControl=101.
   - RegWrite high exactly 1 cycle (WB).
   - pc 0→4, instret 0→1.
2. lw $1,0($2): 32'h8C410000 → ALUSrc=1, MemRead=1 DECODE..WB, MemToReg=0, RegDst=0, RegWrite 1 cycle in WB, MemWrite never high.
3. sw $1,0($2): 32'hAC410000 → MemWrite high exactly 1 cycle (MEM), RegWrite never high, 3 cycles DECODE..MEM.
4. beq $1,$2,+3 at pc=32'h10: alu_zero=1 → pc=32'h20. Repeat with alu_zero=0 → pc=32'h14. ALUControl=110 in both runs.
5. Illegal opcode 32'hFC000000 → illegal pulses 1 cycle, no strobes, instret unchanged, pc += 4.
6. Fetch stall then reset:
   - Hold imem_valid=0 for 5 cycles → imem_req stays 1 and all controls stay 0.
   - Assert rst_n=0 mid-lw in MEM → outputs 0 asynchronously, pc=PC_RESET after release, next instruction fetches from 0.
